percept_host: RTL
=================

// Module: percept_host
// PURPOSE
//  Host-side driver for the serial perceptron MAC unit. Takes parallel operand pairs
//  (valid/ready) and serialises them onto the unit's shift_in/data_in port, then strobes
//  mul_and_acc. On a read request it flushes the unit's one-deep product pipeline,
//  shifts the 4*SIZE-bit accumulator out and returns it as a parallel word.
//  Sits between the weight/input sequencer and one MAC instance; both share clk/nRst.
// PARAMETERS
//  SIZE  32  operand width; MAC accumulator is 4*SIZE bits
// PORTS
//  clk          in   1       clock, rising edge
//  nRst         in   1       reset, asynchronous, active-low
//  op_valid     in   1       operand pair offered
//  op_ready     out  1       high only in IDLE with rd_req not being taken
//  op_a         in   SIZE    operand landing in MAC data_1
//  op_b         in   SIZE    operand landing in MAC data_2
//  rd_req       in   1       request accumulator read (level, sampled in IDLE)
//  res_valid    out  1       one-cycle pulse, res valid
//  res          out  4*SIZE  accumulator value, held until next read completes
//  shift_in     out  1       MAC shift-in strobe
//  shift_out    out  1       MAC shift-out strobe
//  mul_and_acc  out  1       MAC multiply/accumulate strobe
//  data_in      out  1       MAC serial data in
//  data_out     in   1       MAC serial data out (registered in MAC)
// BEHAVIOUR
//  Reset: all outputs 0, res=0, state IDLE, pending=0. Reset mid-operation aborts;
//   MAC resets on the same nRst, so no partial state survives.
//  All registers in one clocked process. shift_in/shift_out/mul_and_acc one-hot or zero
//   every cycle (MAC ignores multi-hot). Strobes and data_in are registered outputs.
//  IDLE: op_valid has priority over rd_req. Accept when op_valid&op_ready: latch
//   {op_b,op_a} into a 2*SIZE shift reg -> LOAD. Else rd_req -> FLUSH_LOAD if pending,
//   else READ.
//  LOAD: 2*SIZE cycles shift_in=1, data_in = MSB of shift reg (op_b MSB first, then op_a
//   MSB first); MAC's data_1->data_2 chaining then yields data_2=op_b, data_1=op_a.
//  MAC: one cycle mul_and_acc=1, pending<=1 -> IDLE. Accept at cycle 0 => strobe at 2*SIZE+1.
//  MAC pipeline: accumulator adds the PREVIOUS product, so the last product is unadded
//   until flushed.
//  FLUSH_LOAD: 2*SIZE cycles shift_in=1, data_in=0. FLUSH_MAC: one mul_and_acc pulse
//   (adds last product, leaves multiplied = 0*0 = 0), pending<=0 -> READ.
//  READ: counter k=0..4*SIZE. shift_out=1 for k<4*SIZE. MAC data_out is valid one cycle
//   after each strobe, so capture res_sr<={res_sr,data_out} for k=1..4*SIZE (MSB first).
//   After k=4*SIZE: res<=res_sr, res_valid=1 for one cycle -> IDLE.
//  Read is destructive: the MAC accumulator is all-zero after 4*SIZE shifts.
//  Sum wraps mod 2^(4*SIZE) inside the MAC; host adds no saturation.
//  rd_req/op_valid changes outside IDLE ignored; op_a/op_b only sampled at accept.
//  Counter width $clog2(4*SIZE+1); never wraps.
// STRUCTURE
//  Shared package: state encoding (IDLE, LOAD, MAC, FLUSH_LOAD, FLUSH_MAC, READ) and
//   width constants OPW=SIZE, LDW=2*SIZE, ACCW=4*SIZE.
//  No sub-module; single FSM + bit counter + load shifter + capture shifter.
//  Bench instantiates percept_host wired to the MAC unit.
// TESTING (SIZE=8, host + MAC instance)
//  1 op (a=3,b=5) then rd_req -> one flush, res=15, res_valid single pulse;
//    mul_and_acc seen at accept+17.
//  2 ops (3,5),(7,9) then read -> res=78; second read with no ops -> res=0, no
//    mul_and_acc or shift_in during read.
//  (255,255) x4 then read -> res=260100; read immediately after -> 0.
//  op_valid and rd_req asserted same cycle in IDLE -> op accepted first, then read
//    -> product returned.
//  Every cycle: at most one strobe high; op_ready low outside IDLE and while a read is taken.
//  nRst pulse mid-LOAD -> all outputs 0 next cycle; then op (2,4) + read -> res=8.

Source files
------------

// File: rtl/percept_host_pkg.sv
// Shared encodings and width helpers for the perceptron MAC host driver.
package percept_host_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    MAC        = 3'd2,
    FLUSH_LOAD = 3'd3,
    FLUSH_MAC  = 3'd4,
    READ       = 3'd5
  } state_t;

  function automatic int opw_of(input int size);
    return size;
  endfunction

  function automatic int ldw_of(input int size);
    return 2 * size;
  endfunction

  function automatic int accw_of(input int size);
    return 4 * size;
  endfunction

endpackage

// File: rtl/percept_host.sv
// Host driver for the serial perceptron MAC: serialises operand pairs, strobes
// multiply/accumulate, flushes the product pipeline and shifts the accumulator back out.
module percept_host
  import percept_host_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [SIZE-1:0]     op_a,
  input  logic [SIZE-1:0]     op_b,
  input  logic                rd_req,
  output logic                res_valid,
  output logic [4*SIZE-1:0]   res,
  output logic                shift_in,
  output logic                shift_out,
  output logic                mul_and_acc,
  output logic                data_in,
  input  logic                data_out
);

  localparam int OPW  = opw_of(SIZE);
  localparam int LDW  = ldw_of(SIZE);
  localparam int ACCW = accw_of(SIZE);
  localparam int CW   = $clog2(ACCW + 1);

  localparam logic [CW-1:0] LDW_C  = CW'(LDW);
  localparam logic [CW-1:0] ACCW_C = CW'(ACCW);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [LDW-1:0]  load_sr;
  logic [ACCW-1:0] res_sr;
  logic            pending;
  logic            take_op;
  logic            take_rd;

  // op_valid wins over rd_req, so a read is only "taken" when no operand is offered.
  assign op_ready = (state == IDLE) && (op_valid || !rd_req);
  assign take_op  = op_valid && op_ready;
  assign take_rd  = (state == IDLE) && rd_req && !op_valid;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      cnt         <= '0;
      load_sr     <= '0;
      res_sr      <= '0;
      pending     <= 1'b0;
      res         <= '0;
      res_valid   <= 1'b0;
      shift_in    <= 1'b0;
      shift_out   <= 1'b0;
      mul_and_acc <= 1'b0;
      data_in     <= 1'b0;
    end else begin
      shift_in    <= 1'b0;
      shift_out   <= 1'b0;
      mul_and_acc <= 1'b0;
      data_in     <= 1'b0;
      res_valid   <= 1'b0;

      case (state)
        IDLE: begin
          if (take_op) begin
            shift_in <= 1'b1;
            data_in  <= op_b[OPW-1];
            load_sr  <= {op_b[OPW-2:0], op_a, 1'b0};
            cnt      <= CW'(1);
            state    <= LOAD;
          end else if (take_rd) begin
            if (pending) begin
              // Shifting zeros makes the flush multiply 0*0, leaving nothing behind.
              shift_in <= 1'b1;
              data_in  <= 1'b0;
              load_sr  <= '0;
              cnt      <= CW'(1);
              state    <= FLUSH_LOAD;
            end else begin
              shift_out <= 1'b1;
              cnt       <= '0;
              state     <= READ;
            end
          end
        end

        LOAD, FLUSH_LOAD: begin
          if (cnt < LDW_C) begin
            shift_in <= 1'b1;
            data_in  <= load_sr[LDW-1];
            load_sr  <= {load_sr[LDW-2:0], 1'b0};
            cnt      <= cnt + 1'b1;
          end else begin
            mul_and_acc <= 1'b1;
            state       <= (state == LOAD) ? MAC : FLUSH_MAC;
          end
        end

        MAC: begin
          pending <= 1'b1;
          state   <= IDLE;
        end

        FLUSH_MAC: begin
          pending   <= 1'b0;
          shift_out <= 1'b1;
          cnt       <= '0;
          state     <= READ;
        end

        READ: begin
          // data_out lags each shift_out by one cycle, so capture runs k=1..ACCW.
          if (cnt != '0) begin
            res_sr <= {res_sr[ACCW-2:0], data_out};
          end
          if (cnt == ACCW_C) begin
            res       <= {res_sr[ACCW-2:0], data_out};
            res_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            shift_out <= ((cnt + 1'b1) < ACCW_C);
            cnt       <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
